// File: rtl/daserial_fir.sv
// Bit-serial distributed-arithmetic 3-tap FIR: one bit plane of the tap
// delay line per clock, LSB first, shift-accumulated into a registered result.
module daserial_fir #(
    parameter int                     W_IN  = 4,
    parameter int                     W_C   = 3,
    parameter logic signed [W_C-1:0]  C0    = 3'sd2,
    parameter logic signed [W_C-1:0]  C1    = 3'sd3,
    parameter logic signed [W_C-1:0]  C2    = 3'sd1,
    parameter int                     W_OUT = W_IN + W_C + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_IN-1:0]  x_in,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [W_OUT-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    localparam int KW = (W_IN > 2) ? $clog2(W_IN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W_IN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic signed [W_OUT-1:0] ZERO = {W_OUT{1'b0}};
    localparam logic signed [W_OUT-1:0] C0E  = {{(W_OUT-W_C){C0[W_C-1]}}, C0};
    localparam logic signed [W_OUT-1:0] C1E  = {{(W_OUT-W_C){C1[W_C-1]}}, C1};
    localparam logic signed [W_OUT-1:0] C2E  = {{(W_OUT-W_C){C2[W_C-1]}}, C2};

    // b[j] is the current bit of tap xj; returns the coefficient sum for that plane
    function automatic logic signed [W_OUT-1:0] da_table(input logic [2:0] b);
        return (b[0] ? C0E : ZERO) + (b[1] ? C1E : ZERO) + (b[2] ? C2E : ZERO);
    endfunction

    logic [1:0]              state_q, state_d;
    logic [W_IN-1:0]         x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [W_OUT-1:0] acc_q, acc_d;
    logic [KW-1:0]           k_q, k_d;
    logic [W_OUT-1:0]        y_q, y_d;
    logic                    y_valid_q, y_valid_d;
    logic                    x_ready_q, x_ready_d;
    logic signed [W_OUT-1:0] plane_s;

    assign plane_s = da_table({x2_q[k_q], x1_q[k_q], x0_q[k_q]}) <<< k_q;

    // Next-state logic for the IDLE/CALC/HOLD sequencer and datapath
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        acc_d     = acc_q;
        k_d       = k_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    x2_d    = x1_q;
                    x1_d    = x0_q;
                    x0_d    = x_in;
                    acc_d   = ZERO;
                    k_d     = {KW{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // The MSB plane carries negative weight in two's complement
                if (k_q == K_LAST) begin
                    acc_d     = acc_q - plane_s;
                    y_d       = acc_q - plane_s;
                    y_valid_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    acc_d = acc_q + plane_s;
                    k_d   = k_q + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d   = HOLD;
                end
            end
            default: begin
                state_d   = IDLE;
                y_valid_d = 1'b0;
            end
        endcase
        x_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x0_q      <= {W_IN{1'b0}};
            x1_q      <= {W_IN{1'b0}};
            x2_q      <= {W_IN{1'b0}};
            acc_q     <= ZERO;
            k_q       <= {KW{1'b0}};
            y_q       <= {W_OUT{1'b0}};
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            x_ready_q <= x_ready_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign x_ready = x_ready_q;

endmodule

// File: tb/tb_daserial_fir.sv
// Directed self-checking bench for daserial_fir (W_IN=4, C0=2, C1=3, C2=1).
module tb_daserial_fir;

    logic       clk;
    logic       reset;
    logic [3:0] x_in;
    logic       x_valid;
    logic       x_ready;
    logic [8:0] y;
    logic       y_valid;
    logic       y_ready;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    daserial_fir dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        x_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // waits (bounded) for x_ready, then presents x for exactly one edge
    task automatic accept(input int x);
        int n;
        n = 0;
        while (!x_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("x_ready_timeout", 0, 1);
        x_in    = 4'(x);
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
    endtask

    // edges counted from the acceptance edge until y_valid; -1 on timeout
    task automatic wait_y(output int l);
        int n;
        n = 1;
        l = -1;
        while (n <= 20) begin
            step();
            if (y_valid) begin
                l = n;
                break;
            end
            n++;
        end
    endtask

    task automatic run(input string tag, input int x, input int exp);
        int l;
        accept(x);
        wait_y(l);
        chk({tag, "_lat"}, l, 4);
        chk(tag, $signed(y), exp);
        step();
    endtask

    initial begin
        x_in    = 4'd0;
        x_valid = 1'b0;
        y_ready = 1'b1;
        do_reset();
        chk("rst_y", $signed(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_x_ready", int'(x_ready), 1);

        run("first_x1", 1, 2);
        chk("idle_after_y", int'(x_ready), 1);
        chk("y_valid_dropped", int'(y_valid), 0);

        do_reset();
        run("seq_1", 1, 2);
        run("seq_m1", -1, 1);
        run("seq_7", 7, 12);
        run("seq_m8", -8, 4);

        do_reset();
        run("max_a", 7, 14);
        run("max_b", 7, 35);
        run("max_c", 7, 42);
        run("min_a", -8, 12);
        run("min_b", -8, -33);
        run("min_c", -8, -48);

        // backpressure: offered sample during HOLD must not be consumed
        do_reset();
        y_ready = 1'b0;
        accept(3);
        wait_y(lat);
        chk("bp_lat", lat, 4);
        chk("bp_y", $signed(y), 6);
        x_in    = 4'd5;
        x_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_y", $signed(y), 6);
            chk("bp_hold_y_valid", int'(y_valid), 1);
            chk("bp_hold_x_ready", int'(x_ready), 0);
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        step();
        chk("bp_rel_y_valid", int'(y_valid), 0);
        chk("bp_rel_x_ready", int'(x_ready), 1);
        chk("bp_rel_y_kept", $signed(y), 6);
        run("bp_next", 1, 11);

        // reset in the middle of a calculation
        accept(5);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (y_valid) seen++;
            step();
        end
        chk("midcalc_no_y_valid", seen, 0);
        chk("midcalc_x_ready", int'(x_ready), 1);
        run("midcalc_next", 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
